// File: rtl/axis_pkt_gen_pkg.sv
// Shared types and helpers for the AXI-Stream packet generator.
// Pure definitions: no latency, no backpressure.
package axis_pkt_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } pkt_gen_state_e;

    localparam logic MODE_INC  = 1'b0;
    localparam logic MODE_LFSR = 1'b1;

    // x^32 + x^22 + x^2 + x + 1 with the x^32 term implicit.
    localparam logic [31:0] LFSR_POLY = 32'h0040_0007;

    // Fibonacci form: x^32 taps bit 31 and x^k taps bit k-1.
    localparam logic [31:0] LFSR_TAPS = {1'b0, LFSR_POLY[31:1]};

    function automatic logic [31:0] lfsr_next(logic [31:0] s);
        logic fb;
        fb = s[31] ^ (^(s & LFSR_TAPS));
        return {s[30:0], fb};
    endfunction

endpackage

// File: rtl/axis_pkt_gen_if.sv
// AXI4-Stream bundle between the packet generator and its sink.
// Wires only: no latency; TREADY from the sink is the only backpressure.
interface axis_pkt_gen_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 4,
    parameter int TDEST_WIDTH = 4,
    parameter int TUSER_WIDTH = 1
);

    logic                     TVALID;
    logic                     TREADY;
    logic [TDATA_WIDTH-1:0]   TDATA;
    logic [TDATA_WIDTH/8-1:0] TSTRB;
    logic [TDATA_WIDTH/8-1:0] TKEEP;
    logic                     TLAST;
    logic [TID_WIDTH-1:0]     TID;
    logic [TDEST_WIDTH-1:0]   TDEST;
    logic [TUSER_WIDTH-1:0]   TUSER;

    modport master (
        output TVALID,
        output TDATA,
        output TSTRB,
        output TKEEP,
        output TLAST,
        output TID,
        output TDEST,
        output TUSER,
        input  TREADY
    );

    modport slave (
        input  TVALID,
        input  TDATA,
        input  TSTRB,
        input  TKEEP,
        input  TLAST,
        input  TID,
        input  TDEST,
        input  TUSER,
        output TREADY
    );

endinterface

// File: rtl/axis_pkt_gen_data.sv
// Data pattern register: incrementing counter or 32-bit LFSR.
// New value one cycle after load/advance; holds while neither strobe is set.
module axis_pkt_gen_data
    import axis_pkt_gen_pkg::*;
#(
    parameter int TDATA_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic                   advance_i,
    input  logic                   mode_i,
    input  logic [31:0]            seed_i,
    output logic [TDATA_WIDTH-1:0] data_o
);

    logic [31:0] value_q;
    logic [31:0] value_d;
    logic        mode_q;
    logic        mode_d;

    always_comb begin
        value_d = value_q;
        mode_d  = mode_q;
        if (load_i) begin
            mode_d = mode_i;
            // An all-zero LFSR would lock up, so seed 0 is promoted to 1.
            if (mode_i == MODE_LFSR && seed_i == 32'd0) begin
                value_d = 32'd1;
            end else begin
                value_d = seed_i;
            end
        end else if (advance_i) begin
            if (mode_q == MODE_LFSR) begin
                value_d = lfsr_next(value_q);
            end else begin
                value_d = value_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_q <= 32'd0;
            mode_q  <= MODE_INC;
        end else begin
            value_q <= value_d;
            mode_q  <= mode_d;
        end
    end

    assign data_o = TDATA_WIDTH'(value_q);

endmodule

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream packet source: programmable length, count, gap and data pattern.
// First beat one cycle after start; beats hold stable while TREADY is low.
module axis_pkt_gen
    import axis_pkt_gen_pkg::*;
#(
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 4,
    parameter int TDEST_WIDTH = 4,
    parameter int TUSER_WIDTH = 1,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   start,
    input  logic [LEN_WIDTH-1:0]   pkt_len,
    input  logic [LEN_WIDTH-1:0]   pkt_count,
    input  logic [LEN_WIDTH-1:0]   gap,
    input  logic                   mode,
    input  logic [31:0]            seed,
    input  logic [TID_WIDTH-1:0]   cfg_tid,
    input  logic [TDEST_WIDTH-1:0] cfg_tdest,
    axis_pkt_gen_if.master         m_axis,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            beats_sent
);

    localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

    pkt_gen_state_e         state_q,  state_d;
    logic [LEN_WIDTH-1:0]   len_q,    len_d;
    logic [LEN_WIDTH-1:0]   count_q,  count_d;
    logic [LEN_WIDTH-1:0]   gap_q,    gap_d;
    logic [TID_WIDTH-1:0]   tid_q,    tid_d;
    logic [TDEST_WIDTH-1:0] tdest_q,  tdest_d;
    logic [LEN_WIDTH-1:0]   beat_q,   beat_d;
    logic [LEN_WIDTH-1:0]   pkt_q,    pkt_d;
    logic [LEN_WIDTH-1:0]   gcnt_q,   gcnt_d;
    logic                   done_q,   done_d;
    logic [31:0]            beats_q,  beats_d;

    logic                   load;
    logic                   advance;
    logic                   sending;
    logic                   last_beat;
    logic                   last_pkt;
    logic [TDATA_WIDTH-1:0] pattern;

    assign sending   = (state_q == SEND);
    assign last_beat = (beat_q == len_q - ONE);
    assign last_pkt  = (pkt_q == count_q - ONE);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        gap_d   = gap_q;
        tid_d   = tid_q;
        tdest_d = tdest_q;
        beat_d  = beat_q;
        pkt_d   = pkt_q;
        gcnt_d  = gcnt_q;
        done_d  = 1'b0;
        beats_d = beats_q;
        load    = 1'b0;
        advance = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = pkt_len;
                    count_d = pkt_count;
                    gap_d   = gap;
                    tid_d   = cfg_tid;
                    tdest_d = cfg_tdest;
                    beat_d  = '0;
                    pkt_d   = '0;
                    load    = 1'b1;
                    // An empty run completes immediately without touching the bus.
                    if (pkt_len == '0 || pkt_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SEND;
                    end
                end
            end

            SEND: begin
                if (m_axis.TREADY) begin
                    advance = 1'b1;
                    beats_d = beats_q + 32'd1;
                    if (last_beat && last_pkt) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        if (last_beat) begin
                            beat_d = '0;
                            pkt_d  = pkt_q + ONE;
                        end else begin
                            beat_d = beat_q + ONE;
                        end
                        if (gap_q != '0) begin
                            state_d = GAP;
                            gcnt_d  = gap_q;
                        end
                    end
                end
            end

            GAP: begin
                gcnt_d = gcnt_q - ONE;
                if (gcnt_q <= ONE) begin
                    state_d = SEND;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
            len_q   <= '0;
            count_q <= '0;
            gap_q   <= '0;
            tid_q   <= '0;
            tdest_q <= '0;
            beat_q  <= '0;
            pkt_q   <= '0;
            gcnt_q  <= '0;
            done_q  <= 1'b0;
            beats_q <= 32'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            gap_q   <= gap_d;
            tid_q   <= tid_d;
            tdest_q <= tdest_d;
            beat_q  <= beat_d;
            pkt_q   <= pkt_d;
            gcnt_q  <= gcnt_d;
            done_q  <= done_d;
            beats_q <= beats_d;
        end
    end

    axis_pkt_gen_data #(
        .TDATA_WIDTH (TDATA_WIDTH)
    ) u_data (
        .clk_i     (ACLK),
        .rst_i     (ARESET),
        .load_i    (load),
        .advance_i (advance),
        .mode_i    (mode),
        .seed_i    (seed),
        .data_o    (pattern)
    );

    // Every bus output decodes from registers, so nothing moves during a stall.
    assign m_axis.TVALID = sending;
    assign m_axis.TDATA  = pattern;
    assign m_axis.TSTRB  = '1;
    assign m_axis.TKEEP  = '1;
    assign m_axis.TLAST  = sending && last_beat;
    assign m_axis.TID    = tid_q;
    assign m_axis.TDEST  = tdest_q;
    assign m_axis.TUSER  = TUSER_WIDTH'(sending && beat_q == '0);

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign beats_sent = beats_q;

endmodule
